pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central pipeline controller. It generates the stall[5:0] vector, flush and new_pc consumed by the pc_reg, if_id, id_ex, ex_mem and mem_wb stage registers.
- Arbitrates stall requests from the IF, ID, EX and MEM stages. Turns the MEM-stage exception type into a one-cycle flush plus a redirect PC.
- Enforces a post-flush recovery window and keeps stall/flush statistics plus a stall watchdog for debug.

Parameters:
- RECOVER_CYCLES, 1, cycles after a flush during which new exceptions are masked (0..15; 0 = no window).
- WDOG_LIMIT, 1024, consecutive stalled cycles that trip the watchdog (>=1).
- INT_VECTOR, 32'h00000020, redirect target for an interrupt.
- EXC_VECTOR, 32'h00000040, redirect target for all other non-ERET exceptions.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stallreq_from_if  in  1  IF fetch not complete
- stallreq_from_id  in  1  ID load-use hazard
- stallreq_from_ex  in  1  EX multi-cycle operation busy
- stallreq_from_mem  in  1  MEM data access not complete
- excepttype_i  in  32  final exception type from MEM stage; 0 = none
- cp0_epc_i  in  32  EPC value (forwarded) for ERET
- stall  out  6  bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb; 1 = hold
- flush  out  1  clear all stage registers this cycle
- new_pc  out  32  redirect address, valid only while flush=1
- in_recover_o  out  1  recovery window active
- wdog_o  out  1  sticky watchdog trip
- stall_cnt_o  out  32  total cycles with stall != 0
- flush_cnt_o  out  16  total flushes

Behaviour:
- State: RUN, RECOVER. Stored: 4-bit recover counter, watchdog run counter, statistics counters, wdog flag.
- stall, flush and new_pc are combinational from the current state and inputs. While rst=1 they are forced to 0.
- Reset (clk edge with rst=1): state RUN, all counters 0, wdog_o=0, in_recover_o=0.
- Exception taken = state RUN and excepttype_i != 0.
- When an exception is taken:
  - flush=1, stall=6'b000000.
  - new_pc depends on excepttype_i: 32'h1 -> INT_VECTOR; 32'hE (ERET) -> cp0_epc_i; any other nonzero value -> EXC_VECTOR.
  - Stall requests are ignored that cycle.
- Otherwise flush=0 and new_pc=0. stall is set by fixed priority:
  - mem -> 6'b011111
  - ex -> 6'b001111
  - id -> 6'b000111
  - if -> 6'b000011
  - none -> 6'b000000
- Transitions:
  - RUN with exception taken: if RECOVER_CYCLES=0, stay in RUN. Else go to RECOVER and load counter = RECOVER_CYCLES-1.
  - RECOVER: excepttype_i is ignored (no flush); stall arbitration proceeds normally. If counter==0, go to RUN; else decrement.
- in_recover_o = (state==RECOVER), registered.
- Consecutive exceptions: with RECOVER_CYCLES=1, an exception presented in the cycle right after a flush is masked. The same value held one more cycle is taken (second flush).
- Watchdog run counter:
  - Cleared when stall==0 or flush=1; otherwise increments, saturating at WDOG_LIMIT.
  - wdog_o sets at the edge where the counter reaches WDOG_LIMIT, i.e. after exactly WDOG_LIMIT consecutive stalled cycles. It stays set until rst.
  - The watchdog does not alter stall.
- stall_cnt_o increments each cycle stall != 0; wraps at 2^32.
- flush_cnt_o increments each cycle flush=1; wraps at 2^16.
- Reset mid-recovery: returns to RUN immediately. The next exception is taken normally.
- Output latency: stall/flush/new_pc have 0 cycles. in_recover_o, the counters and wdog_o are visible 1 cycle after the causing event.

Test Plan:
- Reset, then stallreq_from_ex=1 and stallreq_from_id=1 together -> stall=6'b001111; drop ex -> 6'b000111; drop all -> 0. stall_cnt_o=2 on the following cycle.
- excepttype_i=32'h8 with stallreq_from_mem=1 -> same cycle flush=1, stall=0, new_pc=32'h40; next cycle in_recover_o=1, flush_cnt_o=1.
- excepttype_i=32'hE, cp0_epc_i=32'h00000100 -> flush=1, new_pc=32'h100. Hold excepttype_i: next cycle flush=0 (masked). The cycle after: flush=1 again, flush_cnt_o=2.
- excepttype_i=32'h1 -> new_pc=32'h20. Assert rst during RECOVER, release, apply 32'hC -> flush=1, new_pc=32'h40.
- WDOG_LIMIT=4, stallreq_from_if held 3 cycles then released -> wdog_o=0. Held 4 cycles -> wdog_o=1 after the 4th edge and stays 1 after release.
- 2^16 flushes (excepttype_i pulsed every RECOVER_CYCLES+1 cycles) -> flush_cnt_o wraps to 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: stall arbitration, exception flush/redirect,
// post-flush recovery window, stall/flush statistics and a stall watchdog.
module pipe_ctrl #(
  parameter int unsigned RECOVER_CYCLES = 1,
  parameter int unsigned WDOG_LIMIT     = 1024,
  parameter logic [31:0] INT_VECTOR     = 32'h0000_0020,
  parameter logic [31:0] EXC_VECTOR     = 32'h0000_0040
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        in_recover_o,
  output logic        wdog_o,
  output logic [31:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o
);

  localparam int unsigned WDOG_W = $clog2(WDOG_LIMIT + 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_LIMIT);
  localparam logic [3:0] REC_LOAD = (RECOVER_CYCLES == 0) ? 4'd0 : 4'(RECOVER_CYCLES - 1);

  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ERET = 32'h0000_000E;

  typedef enum logic {RUN, RECOVER} state_t;

  state_t            state, state_next;
  logic [3:0]        rec_cnt, rec_cnt_next;
  logic [WDOG_W-1:0] run_cnt, run_cnt_next;
  logic              exc_taken;

  assign exc_taken = !rst && (state == RUN) && (excepttype_i != 32'd0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      rec_cnt <= 4'd0;
    end else begin
      state   <= state_next;
      rec_cnt <= rec_cnt_next;
    end
  end

  // NOTE: every variable gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_next   = state;
    rec_cnt_next = rec_cnt;
    case (state)
      RUN: begin
        if (exc_taken && RECOVER_CYCLES != 0) begin
          state_next   = RECOVER;
          rec_cnt_next = REC_LOAD;
        end
      end
      RECOVER: begin
        if (rec_cnt == 4'd0) state_next = RUN;
        else                 rec_cnt_next = rec_cnt - 4'd1;
      end
      default: state_next = RUN;
    endcase
  end

  // Exceptions are masked in RECOVER; stall arbitration never is.
  always_comb begin
    stall  = 6'b000000;
    flush  = 1'b0;
    new_pc = 32'd0;
    if (!rst) begin
      if (exc_taken) begin
        flush = 1'b1;
        case (excepttype_i)
          EXC_INT:  new_pc = INT_VECTOR;
          EXC_ERET: new_pc = cp0_epc_i;
          default:  new_pc = EXC_VECTOR;
        endcase
      end else if (stallreq_from_mem) begin
        stall = 6'b011111;
      end else if (stallreq_from_ex) begin
        stall = 6'b001111;
      end else if (stallreq_from_id) begin
        stall = 6'b000111;
      end else if (stallreq_from_if) begin
        stall = 6'b000011;
      end
    end
  end

  assign in_recover_o = (state == RECOVER);

  always_comb begin
    run_cnt_next = run_cnt;
    if (stall == 6'b000000 || flush) run_cnt_next = '0;
    else if (run_cnt != WDOG_MAX)    run_cnt_next = run_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt     <= '0;
      wdog_o      <= 1'b0;
      stall_cnt_o <= 32'd0;
      flush_cnt_o <= 16'd0;
    end else begin
      run_cnt <= run_cnt_next;
      if (run_cnt_next == WDOG_MAX) wdog_o <= 1'b1;
      if (stall != 6'b000000)       stall_cnt_o <= stall_cnt_o + 32'd1;
      if (flush)                    flush_cnt_o <= flush_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: the driver pushes hand-computed expectations,
// a negedge monitor pops and compares them against the selected instance.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: RECOVER_CYCLES=1, WDOG_LIMIT=4
  logic        rst;
  logic        rq_if, rq_id, rq_ex, rq_mem;
  logic [31:0] exc, epc;
  logic [5:0]  stall;
  logic        flush, in_rec, wdog;
  logic [31:0] new_pc, scnt;
  logic [15:0] fcnt;

  // Wrap instance: RECOVER_CYCLES=0 so it can flush every cycle
  logic        rst0;
  logic [31:0] exc0;
  logic [5:0]  stall0;
  logic        flush0, in_rec0, wdog0;
  logic [31:0] new_pc0, scnt0;
  logic [15:0] fcnt0;

  pipe_ctrl #(.RECOVER_CYCLES(1), .WDOG_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .stallreq_from_if(rq_if), .stallreq_from_id(rq_id),
    .stallreq_from_ex(rq_ex), .stallreq_from_mem(rq_mem),
    .excepttype_i(exc), .cp0_epc_i(epc),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .in_recover_o(in_rec), .wdog_o(wdog),
    .stall_cnt_o(scnt), .flush_cnt_o(fcnt)
  );

  pipe_ctrl #(.RECOVER_CYCLES(0), .WDOG_LIMIT(4)) dut0 (
    .clk(clk), .rst(rst0),
    .stallreq_from_if(1'b0), .stallreq_from_id(1'b0),
    .stallreq_from_ex(1'b0), .stallreq_from_mem(1'b0),
    .excepttype_i(exc0), .cp0_epc_i(32'd0),
    .stall(stall0), .flush(flush0), .new_pc(new_pc0),
    .in_recover_o(in_rec0), .wdog_o(wdog0),
    .stall_cnt_o(scnt0), .flush_cnt_o(fcnt0)
  );

  typedef struct {
    int          tag;
    bit          sel;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] npc;
    logic        inrec;
    logic        wdog;
    bit          chk_cnt;
    logic [31:0] scnt;
    logic [15:0] fcnt;
  } exp_t;

  exp_t q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int tag    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      string p;
      e = q.pop_front();
      p = $sformatf("v%0d", e.tag);
      if (!e.sel) begin
        check({p, ".stall"},  {26'd0, stall}, {26'd0, e.stall});
        check({p, ".flush"},  {31'd0, flush}, {31'd0, e.flush});
        check({p, ".new_pc"}, new_pc, e.npc);
        check({p, ".in_rec"}, {31'd0, in_rec}, {31'd0, e.inrec});
        check({p, ".wdog"},   {31'd0, wdog}, {31'd0, e.wdog});
        if (e.chk_cnt) begin
          check({p, ".stall_cnt"}, scnt, e.scnt);
          check({p, ".flush_cnt"}, {16'd0, fcnt}, {16'd0, e.fcnt});
        end
      end else begin
        check({p, ".w.stall"},  {26'd0, stall0}, {26'd0, e.stall});
        check({p, ".w.flush"},  {31'd0, flush0}, {31'd0, e.flush});
        check({p, ".w.new_pc"}, new_pc0, e.npc);
        check({p, ".w.in_rec"}, {31'd0, in_rec0}, {31'd0, e.inrec});
        check({p, ".w.wdog"},   {31'd0, wdog0}, {31'd0, e.wdog});
        if (e.chk_cnt) begin
          check({p, ".w.stall_cnt"}, scnt0, e.scnt);
          check({p, ".w.flush_cnt"}, {16'd0, fcnt0}, {16'd0, e.fcnt});
        end
      end
    end
  end

  // req = {mem, ex, id, if}
  task automatic step(input logic r, input logic [3:0] req, input logic [31:0] x, input logic [31:0] pc);
    @(posedge clk);
    #1;
    rst = r;
    {rq_mem, rq_ex, rq_id, rq_if} = req;
    exc = x;
    epc = pc;
  endtask

  task automatic expect_v(input bit sel, input logic [5:0] st, input logic fl, input logic [31:0] npc,
                          input logic ir, input logic wd, input bit cc,
                          input logic [31:0] sc, input logic [15:0] fc);
    exp_t e;
    e.tag = tag; e.sel = sel; e.stall = st; e.flush = fl; e.npc = npc;
    e.inrec = ir; e.wdog = wd; e.chk_cnt = cc; e.scnt = sc; e.fcnt = fc;
    q.push_back(e);
    tag++;
  endtask

  initial begin
    rst = 1'b1; {rq_mem, rq_ex, rq_id, rq_if} = 4'b0000; exc = 32'd0; epc = 32'd0;
    rst0 = 1'b1; exc0 = 32'd0;

    // Second reset cycle: requests present but outputs forced to 0
    step(1, 4'b1000, 32'h8, 32'h0);   expect_v(0, 6'b000000, 0, 32'h0,   0, 0, 1, 0, 0);
    // Stall priority and statistics
    step(0, 4'b0110, 32'h0, 32'h0);   expect_v(0, 6'b001111, 0, 32'h0,   0, 0, 1, 0, 0);
    step(0, 4'b0010, 32'h0, 32'h0);   expect_v(0, 6'b000111, 0, 32'h0,   0, 0, 1, 1, 0);
    step(0, 4'b0000, 32'h0, 32'h0);   expect_v(0, 6'b000000, 0, 32'h0,   0, 0, 1, 2, 0);
    step(0, 4'b0001, 32'h0, 32'h0);   expect_v(0, 6'b000011, 0, 32'h0,   0, 0, 1, 2, 0);
    step(0, 4'b1001, 32'h0, 32'h0);   expect_v(0, 6'b011111, 0, 32'h0,   0, 0, 1, 3, 0);
    // Generic exception beats a MEM stall
    step(0, 4'b1000, 32'h8, 32'h0);   expect_v(0, 6'b000000, 1, 32'h40,  0, 0, 1, 4, 0);
    step(0, 4'b0000, 32'h0, 32'h0);   expect_v(0, 6'b000000, 0, 32'h0,   1, 0, 1, 4, 1);
    // ERET, held: taken, masked, taken again
    step(0, 4'b0000, 32'hE, 32'h100); expect_v(0, 6'b000000, 1, 32'h100, 0, 0, 1, 4, 1);
    step(0, 4'b0000, 32'hE, 32'h100); expect_v(0, 6'b000000, 0, 32'h0,   1, 0, 1, 4, 2);
    step(0, 4'b0000, 32'hE, 32'h100); expect_v(0, 6'b000000, 1, 32'h100, 0, 0, 1, 4, 2);
    // Arbitration continues inside the recovery window
    step(0, 4'b0100, 32'h0, 32'h0);   expect_v(0, 6'b001111, 0, 32'h0,   1, 0, 1, 4, 3);
    // Interrupt, then reset while recovering
    step(0, 4'b0000, 32'h1, 32'h0);   expect_v(0, 6'b000000, 1, 32'h20,  0, 0, 1, 5, 3);
    step(1, 4'b0010, 32'h0, 32'h0);   expect_v(0, 6'b000000, 0, 32'h0,   1, 0, 1, 5, 4);
    step(0, 4'b0000, 32'hC, 32'h0);   expect_v(0, 6'b000000, 1, 32'h40,  0, 0, 1, 0, 0);
    step(0, 4'b0000, 32'h0, 32'h0);   expect_v(0, 6'b000000, 0, 32'h0,   1, 0, 1, 0, 1);
    // Large unknown code still maps to EXC_VECTOR, not EPC
    step(0, 4'b0000, 32'h8000_0000, 32'h100);
                                      expect_v(0, 6'b000000, 1, 32'h40,  0, 0, 1, 0, 1);
    step(0, 4'b0000, 32'h0, 32'h0);   expect_v(0, 6'b000000, 0, 32'h0,   1, 0, 1, 0, 2);
    // Watchdog: 3 stalled cycles do not trip it
    for (int i = 0; i < 3; i++) begin
      step(0, 4'b0001, 32'h0, 32'h0); expect_v(0, 6'b000011, 0, 32'h0, 0, 0, 0, 0, 0);
    end
    step(0, 4'b0000, 32'h0, 32'h0);   expect_v(0, 6'b000000, 0, 32'h0,   0, 0, 1, 3, 2);
    // 4 stalled cycles trip it after the 4th edge; sticky afterwards
    for (int i = 0; i < 4; i++) begin
      step(0, 4'b0001, 32'h0, 32'h0); expect_v(0, 6'b000011, 0, 32'h0, 0, 0, 0, 0, 0);
    end
    step(0, 4'b0000, 32'h0, 32'h0);   expect_v(0, 6'b000000, 0, 32'h0,   0, 1, 1, 7, 2);
    step(0, 4'b0000, 32'h0, 32'h0);   expect_v(0, 6'b000000, 0, 32'h0,   0, 1, 1, 7, 2);

    // flush_cnt_o wrap: 65536 back-to-back flushes on the wrap instance
    for (int i = 0; i < 65535; i++) begin
      @(posedge clk);
      #1;
      rst0 = 1'b0;
      exc0 = 32'h4;
    end
    @(posedge clk); #1;
    exc0 = 32'h4;                     expect_v(1, 6'b000000, 1, 32'h40,  0, 0, 1, 0, 16'hFFFF);
    @(posedge clk); #1;
    exc0 = 32'h0;                     expect_v(1, 6'b000000, 0, 32'h0,   0, 0, 1, 0, 16'h0000);

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
